mvu_fold_ctrl: RTL and testbench
================================

# mvu_fold_ctrl

Fold sequencer for one MVU processing-element column. It accepts input-activation beats over a valid/ready stream and stores them in the input buffer during the first neuron fold. It replays those beats from the buffer for the remaining NF-1 neuron folds, while driving weight-memory addresses and pipeline-aligned accumulator controls (`sf_clr`, `acc_en`). It presents each finished dot product to the downstream stream with backpressure.

## Interface
Parameters:
- `SF`, 4: synapse fold, the number of SIMD beats per output.
- `NF`, 2: neuron fold, the number of output rows per input vector.
- `PIPE`, 2: number of `pe_en`-gated stages from beat issue to the accumulator input (weight read plus SIMD register).
- `SF_T`, `$clog2(SF)` (minimum 1): width of the SF counter.
- `NF_T`, `$clog2(NF)` (minimum 1): width of the NF counter.
- `WA_T`, `$clog2(SF*NF)` (minimum 1): width of the weight address.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_v` in 1: input activation beat valid.
- `in_rdy` out 1: input beat accepted when `in_v & in_rdy`.
- `out_rdy` in 1: downstream ready.
- `out_v` out 1: accumulator output valid.
- `out_nf` out NF_T: neuron-fold index of the presented output.
- `pe_en` out 1: enable for every datapath pipeline register and the accumulator.
- `ib_wr_en` out 1: input-buffer write strobe.
- `ib_wr_addr` out SF_T: input-buffer write address.
- `ib_rd_addr` out SF_T: input-buffer read address.
- `ib_sel` out 1: 1 selects the live input into the PE; 0 selects the buffer read data.
- `wmem_addr` out WA_T: weight-memory address of the issued beat.
- `sf_clr` out 1: at the accumulator input, load instead of add (first beat of a row).
- `acc_en` out 1: the accumulator-input beat is real; a bubble is not accumulated.

## Operation
- **Counters**
  - `sf` counts 0..SF-1.
  - `nf` counts 0..NF-1.
  - `wa` counts 0..SF*NF-1 and wraps to 0 after the last beat of the last row.
  - All three advance only on an issued beat.
- **State machine**
  - States are FIRST (nf==0) and REPLAY (nf>0).
  - In FIRST:
    - Issue when `pe_en & in_v`.
    - `in_rdy = pe_en`.
    - `ib_sel = 1`, `ib_wr_en` = issue, `ib_wr_addr = sf`.
  - In REPLAY:
    - Issue every cycle with `pe_en`.
    - `in_rdy = 0`, `ib_sel = 0`, `ib_rd_addr = sf`.
  - FIRST→REPLAY on the issue with sf==SF-1 when NF>1.
  - REPLAY→FIRST on the issue with sf==SF-1 and nf==NF-1.
  - When NF==1 the block stays in FIRST.
- **Combinational issue outputs**
  - `wmem_addr = wa`.
  - `ib_rd_addr` and `ib_wr_addr` equal `sf`.
  - When no issue occurs, the addresses are don't-care and `ib_wr_en = 0`.
- **Tag pipeline**
  - A PIPE-deep shift register of {v, first, last, nf} advances when `pe_en = 1`.
  - v = issue; first = (sf==0); last = (sf==SF-1). With SF==1, every beat is both first and last.
  - Stage PIPE drives `acc_en = v & pe_en` and `sf_clr = v & first`.
- **Output**
  - On `pe_en` with a stage-PIPE tag of v & last, `out_v` is set next cycle and `out_nf` captures the tag's nf.
  - `out_v` clears on `out_v & out_rdy` unless a new result sets it in the same cycle; set wins.
- **Stall rule:** `pe_en = ~(out_v & ~out_rdy)`. The whole pipeline and the counters freeze while an output is held.
- **Bubbles:** missing input in FIRST inserts a v=0 tag. The accumulator is untouched and the row continues when data arrives.

## Timing
- **Reset values:**
  - State FIRST; `sf`, `nf`, `wa` = 0; all tags = 0.
  - `out_v` = 0, `out_nf` = 0, `acc_en` = 0, `sf_clr` = 0, `ib_wr_en` = 0.
  - `pe_en` = 1; `in_rdy` = 1 in the first cycle after reset.
- **Latency:** a beat issued in cycle t reaches the accumulator input in cycle t+PIPE (no stalls). A row's last beat issued at t gives `out_v` = 1 at t+PIPE+1.
- **Throughput:** one beat per cycle. SF=4, NF=2 consumes 4 input beats per 8 issue cycles.
- `in_rdy` depends combinationally on `out_rdy` through `pe_en`. `in_v` must not depend on `in_rdy`.
- **Reset mid-row:** all in-flight tags are discarded and no `out_v` is produced for the partial row. Input acceptance resumes the cycle after `rst` deasserts.
- **Simultaneous events:** `out_v & out_rdy` plus a new last tag keeps `out_v` = 1 with the updated `out_nf`. Downstream sees back-to-back outputs.

## Test plan
- **Baseline:** SF=4, NF=2, PIPE=2, `in_v` high, `out_rdy` high.
  - Beats accepted in cycles 0-3, `in_rdy` low in cycles 4-7.
  - `wmem_addr` 0..7, `ib_wr_addr` 0..3 then `ib_rd_addr` 0..3.
  - `out_v` in cycle 6 (`out_nf` 0) and cycle 10 (`out_nf` 1); `sf_clr` in cycles 2 and 6.
- **Input gaps:** `in_v` low in cycles 1-2.
  - `acc_en` low in cycles 3-4 and no `sf_clr` there.
  - First `out_v` in cycle 8; the accumulated value equals the gap-free result.
- **Backpressure:** `out_rdy` low for 3 cycles while `out_v` = 1.
  - `pe_en` low, and `wmem_addr`, `sf`, and tags frozen for those 3 cycles.
  - No output lost or duplicated; `out_nf` order is 0,1,0,1.
- **Degenerate folds:**
  - SF=1, NF=1: every accepted beat has `sf_clr` = 1 and `acc_en` = 1 and yields `out_v` 2 cycles later. `wmem_addr` is always 0.
  - SF=3, NF=1: no REPLAY; `in_rdy` never drops.
- **Wrap:** three consecutive vectors with SF=4, NF=2. `wmem_addr` wraps 7→0 at the start of each vector, and `in_rdy` re-asserts in cycles 8 and 16.
- **Mid-row reset:** `rst` pulsed in cycle 5 of the baseline.
  - No `out_v` for row 1; `out_v` for row 0 is not produced if still pending.
  - After release, the sequence restarts at `wmem_addr` 0 with FIRST behaviour.

Source files
------------

// File: rtl/mvu_fold_ctrl.sv
// mvu_fold_ctrl: fold sequencer for one MVU PE column. Takes SF input beats in the first
//   neuron fold and writes them into the input buffer. It then replays them for the
//   remaining NF-1 folds. It drives weight addresses and the pipeline-aligned accumulator
//   controls, and holds each finished row on out_v until downstream accepts it.
// Latency: a beat issued in cycle t reaches the accumulator input at t+PIPE.
//   A row's last beat gives out_v at t+PIPE+1.
// Backpressure: pe_en = ~(out_v & ~out_rdy). The counters, the tag pipe and the
//   datapath all freeze while an output is held. in_rdy follows pe_en in FIRST.
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   in_v / in_rdy             - input activation beat handshake
//   out_rdy / out_v / out_nf  - result handshake and the result's neuron-fold index
//   pe_en                     - enable for all datapath pipeline registers and the accumulator
//   ib_wr_en / ib_wr_addr     - input-buffer write strobe and address
//   ib_rd_addr / ib_sel       - input-buffer read address; ib_sel=1 selects the live input
//   wmem_addr                 - weight-memory address of the issued beat
//   sf_clr / acc_en           - accumulator load-vs-add and beat-is-real, at the accumulator input
module mvu_fold_ctrl #(
  parameter int SF   = 4,
  parameter int NF   = 2,
  parameter int PIPE = 2,
  parameter int SF_T = (SF > 1) ? $clog2(SF) : 1,
  parameter int NF_T = (NF > 1) ? $clog2(NF) : 1,
  parameter int WA_T = (SF * NF > 1) ? $clog2(SF * NF) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_v,
  output logic            in_rdy,
  input  logic            out_rdy,
  output logic            out_v,
  output logic [NF_T-1:0] out_nf,
  output logic            pe_en,
  output logic            ib_wr_en,
  output logic [SF_T-1:0] ib_wr_addr,
  output logic [SF_T-1:0] ib_rd_addr,
  output logic            ib_sel,
  output logic [WA_T-1:0] wmem_addr,
  output logic            sf_clr,
  output logic            acc_en
);

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_REPLAY = 1'b1
  } state_t;

  typedef struct packed {
    logic            v;
    logic            first;
    logic            last;
    logic [NF_T-1:0] nf;
  } tag_t;

  localparam logic [SF_T-1:0] SF_MAX = SF_T'(SF - 1);
  localparam logic [NF_T-1:0] NF_MAX = NF_T'(NF - 1);
  localparam logic [WA_T-1:0] WA_MAX = WA_T'(SF * NF - 1);

  state_t          state_q, state_d;
  logic [SF_T-1:0] sf_q, sf_d;
  logic [NF_T-1:0] nf_q, nf_d;
  logic [WA_T-1:0] wa_q, wa_d;
  tag_t            tag_q [PIPE];
  tag_t            tag_d [PIPE];
  logic            out_v_q, out_v_d;
  logic [NF_T-1:0] out_nf_q, out_nf_d;

  logic issue;
  logic sf_last;
  logic in_first;
  tag_t tag_acc;  // tag currently at the accumulator input

  // Combinational issue and handshake outputs.
  always_comb begin
    tag_acc    = tag_q[PIPE-1];
    in_first   = (state_q == ST_FIRST);
    pe_en      = ~(out_v_q & ~out_rdy);
    sf_last    = (sf_q == SF_MAX);
    // FIRST waits on live data; REPLAY streams from the buffer with no gaps.
    issue      = pe_en & (in_first ? in_v : 1'b1);
    in_rdy     = in_first & pe_en;
    ib_sel     = in_first;
    ib_wr_en   = issue & in_first;
    ib_wr_addr = sf_q;
    ib_rd_addr = sf_q;
    wmem_addr  = wa_q;
    acc_en     = tag_acc.v & pe_en;
    sf_clr     = tag_acc.v & tag_acc.first;
    out_v      = out_v_q;
    out_nf     = out_nf_q;
  end

  // Next-state: counters, FSM, tag pipe, output register.
  always_comb begin
    state_d  = state_q;
    sf_d     = sf_q;
    nf_d     = nf_q;
    wa_d     = wa_q;
    out_v_d  = out_v_q;
    out_nf_d = out_nf_q;
    for (int i = 0; i < PIPE; i++) begin
      tag_d[i] = tag_q[i];
    end

    if (issue) begin
      sf_d = sf_last ? '0 : sf_q + SF_T'(1);
      wa_d = (wa_q == WA_MAX) ? '0 : wa_q + WA_T'(1);
      if (sf_last) begin
        nf_d = (nf_q == NF_MAX) ? '0 : nf_q + NF_T'(1);
        case (state_q)
          ST_FIRST:  if (NF > 1) state_d = ST_REPLAY;
          ST_REPLAY: if (nf_q == NF_MAX) state_d = ST_FIRST;
          default:   state_d = ST_FIRST;
        endcase
      end
    end

    // A stalled-out input in FIRST still shifts a v=0 bubble tag in.
    if (pe_en) begin
      tag_d[0].v     = issue;
      tag_d[0].first = (sf_q == '0);
      tag_d[0].last  = sf_last;
      tag_d[0].nf    = nf_q;
      for (int i = 1; i < PIPE; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end

    // A new result overrides the clear from a same-cycle handoff.
    if (out_v_q & out_rdy) begin
      out_v_d = 1'b0;
    end
    if (pe_en & tag_acc.v & tag_acc.last) begin
      out_v_d  = 1'b1;
      out_nf_d = tag_acc.nf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FIRST;
      sf_q     <= '0;
      nf_q     <= '0;
      wa_q     <= '0;
      out_v_q  <= 1'b0;
      out_nf_q <= '0;
      for (int i = 0; i < PIPE; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sf_q     <= sf_d;
      nf_q     <= nf_d;
      wa_q     <= wa_d;
      out_v_q  <= out_v_d;
      out_nf_q <= out_nf_d;
      for (int i = 0; i < PIPE; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mvu_fold_ctrl.sv
// Directed bench for mvu_fold_ctrl. It runs three instances: SF=4/NF=2/PIPE=2,
// SF=1/NF=1/PIPE=1 and SF=3/NF=1/PIPE=2. All three share clk, rst, in_v and out_rdy.
// Cycle c counts from the first cycle after reset release. Inputs change 1 time
// unit after the rising edge, and outputs are checked 1 time unit later.
module tb_mvu_fold_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_v = 1'b0;
  logic out_rdy = 1'b1;

  always #5 clk = ~clk;

  // u0: SF=4 NF=2 PIPE=2
  logic       a_in_rdy, a_out_v, a_out_nf, a_pe_en, a_ib_wr_en, a_ib_sel, a_sf_clr, a_acc_en;
  logic [1:0] a_ib_wr_addr, a_ib_rd_addr;
  logic [2:0] a_wmem_addr;
  // u1: SF=1 NF=1 PIPE=1
  logic b_in_rdy, b_out_v, b_out_nf, b_pe_en, b_ib_wr_en, b_ib_sel, b_sf_clr, b_acc_en;
  logic b_ib_wr_addr, b_ib_rd_addr, b_wmem_addr;
  // u2: SF=3 NF=1 PIPE=2
  logic       c_in_rdy, c_out_v, c_out_nf, c_pe_en, c_ib_wr_en, c_ib_sel, c_sf_clr, c_acc_en;
  logic [1:0] c_ib_wr_addr, c_ib_rd_addr, c_wmem_addr;

  mvu_fold_ctrl #(.SF(4), .NF(2), .PIPE(2)) u0 (
    .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(a_in_rdy), .out_rdy(out_rdy),
    .out_v(a_out_v), .out_nf(a_out_nf), .pe_en(a_pe_en), .ib_wr_en(a_ib_wr_en),
    .ib_wr_addr(a_ib_wr_addr), .ib_rd_addr(a_ib_rd_addr), .ib_sel(a_ib_sel),
    .wmem_addr(a_wmem_addr), .sf_clr(a_sf_clr), .acc_en(a_acc_en));

  mvu_fold_ctrl #(.SF(1), .NF(1), .PIPE(1)) u1 (
    .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(b_in_rdy), .out_rdy(out_rdy),
    .out_v(b_out_v), .out_nf(b_out_nf), .pe_en(b_pe_en), .ib_wr_en(b_ib_wr_en),
    .ib_wr_addr(b_ib_wr_addr), .ib_rd_addr(b_ib_rd_addr), .ib_sel(b_ib_sel),
    .wmem_addr(b_wmem_addr), .sf_clr(b_sf_clr), .acc_en(b_acc_en));

  mvu_fold_ctrl #(.SF(3), .NF(1), .PIPE(2)) u2 (
    .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(c_in_rdy), .out_rdy(out_rdy),
    .out_v(c_out_v), .out_nf(c_out_nf), .pe_en(c_pe_en), .ib_wr_en(c_ib_wr_en),
    .ib_wr_addr(c_ib_wr_addr), .ib_rd_addr(c_ib_rd_addr), .ib_sel(c_ib_sel),
    .wmem_addr(c_wmem_addr), .sf_clr(c_sf_clr), .acc_en(c_acc_en));

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Hand-computed expectations for the input-gap scenario, cycles 0..9.
  int gap_in_v   [10] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  int gap_in_rdy [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int gap_wr_en  [10] = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
  int gap_acc    [10] = '{0, 0, 1, 0, 0, 1, 1, 1, 1, 1};
  int gap_clr    [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
  int gap_out_v  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  int hs_nf [$];
  int acc_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    in_v    = 1'b0;
    out_rdy = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state (rst still high, no input) ----------------
    rst = 1'b1; in_v = 1'b0; out_rdy = 1'b1;
    repeat (3) next_cycle();
    #1;
    check("rst_out_v",    32'(a_out_v), 0);
    check("rst_out_nf",   32'(a_out_nf), 0);
    check("rst_acc_en",   32'(a_acc_en), 0);
    check("rst_sf_clr",   32'(a_sf_clr), 0);
    check("rst_ib_wr_en", 32'(a_ib_wr_en), 0);
    check("rst_pe_en",    32'(a_pe_en), 1);
    check("rst_in_rdy",   32'(a_in_rdy), 1);
    check("rst_wmem",     32'(a_wmem_addr), 0);

    // ---------------- baseline + wrap: three back-to-back vectors ----------------
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      cyc = c; in_v = 1'b1; out_rdy = 1'b1;
      #1;
      check("base_in_rdy", 32'(a_in_rdy), ((c % 8) < 4) ? 1 : 0);
      check("base_ib_sel", 32'(a_ib_sel), ((c % 8) < 4) ? 1 : 0);
      check("base_wr_en",  32'(a_ib_wr_en), ((c % 8) < 4) ? 1 : 0);
      check("base_wmem",   32'(a_wmem_addr), c % 8);
      if ((c % 8) < 4) check("base_wr_addr", 32'(a_ib_wr_addr), c % 8);
      else             check("base_rd_addr", 32'(a_ib_rd_addr), (c % 8) - 4);
      check("base_pe_en",  32'(a_pe_en), 1);
      check("base_acc_en", 32'(a_acc_en), (c >= 2) ? 1 : 0);
      check("base_sf_clr", 32'(a_sf_clr), (c >= 2 && ((c - 2) % 4) == 0) ? 1 : 0);
      check("base_out_v",  32'(a_out_v), (c >= 6 && ((c - 6) % 4) == 0) ? 1 : 0);
      if (c >= 6 && ((c - 6) % 4) == 0) check("base_out_nf", 32'(a_out_nf), ((c - 6) / 4) % 2);
      // SF=1/NF=1/PIPE=1: every beat is first and last, with its output 2 cycles later.
      check("sf1_wmem",   32'(b_wmem_addr), 0);
      check("sf1_acc_en", 32'(b_acc_en), (c >= 1) ? 1 : 0);
      check("sf1_sf_clr", 32'(b_sf_clr), (c >= 1) ? 1 : 0);
      check("sf1_out_v",  32'(b_out_v), (c >= 2) ? 1 : 0);
      // SF=3/NF=1: never replays, so in_rdy stays high.
      check("sf3_in_rdy", 32'(c_in_rdy), 1);
      check("sf3_wmem",   32'(c_wmem_addr), c % 3);
      check("sf3_out_v",  32'(c_out_v), (c >= 5 && ((c - 2) % 3) == 0) ? 1 : 0);
      next_cycle();
    end

    // ---------------- input gaps: in_v low in cycles 1-2 ----------------
    apply_reset();
    acc_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      cyc = c; in_v = gap_in_v[c][0]; out_rdy = 1'b1;
      #1;
      check("gap_in_rdy", 32'(a_in_rdy), gap_in_rdy[c]);
      check("gap_wr_en",  32'(a_ib_wr_en), gap_wr_en[c]);
      check("gap_acc_en", 32'(a_acc_en), gap_acc[c]);
      check("gap_sf_clr", 32'(a_sf_clr), gap_clr[c]);
      check("gap_out_v",  32'(a_out_v), gap_out_v[c]);
      if (c == 5) check("gap_wmem_c5", 32'(a_wmem_addr), 3);
      if (c == 6) check("gap_wmem_c6", 32'(a_wmem_addr), 4);
      if (c == 8) check("gap_out_nf", 32'(a_out_nf), 0);
      if (c >= 2 && c <= 7 && a_acc_en) acc_cnt++;
      next_cycle();
    end
    cyc = 10;
    check("gap_row0_beats", 32'(acc_cnt), 4);

    // ---------------- backpressure: out_rdy low in cycles 6-8 ----------------
    apply_reset();
    hs_nf.delete();
    for (int c = 0; c < 23; c++) begin
      cyc = c; in_v = 1'b1; out_rdy = (c >= 6 && c <= 8) ? 1'b0 : 1'b1;
      #1;
      if (a_out_v && out_rdy) hs_nf.push_back(int'(a_out_nf));
      if (c >= 6 && c <= 8) begin
        check("bp_pe_en",   32'(a_pe_en), 0);
        check("bp_wmem",    32'(a_wmem_addr), 6);
        check("bp_rd_addr", 32'(a_ib_rd_addr), 2);
        check("bp_sf_clr",  32'(a_sf_clr), 1);
        check("bp_acc_en",  32'(a_acc_en), 0);
        check("bp_out_v",   32'(a_out_v), 1);
        check("bp_out_nf",  32'(a_out_nf), 0);
      end
      if (c == 9) begin
        check("bp_rel_pe_en",  32'(a_pe_en), 1);
        check("bp_rel_wmem",   32'(a_wmem_addr), 6);
        check("bp_rel_acc_en", 32'(a_acc_en), 1);
        check("bp_rel_out_v",  32'(a_out_v), 1);
      end
      if (c == 10) check("bp_c10_out_v", 32'(a_out_v), 0);
      if (c == 11) begin
        check("bp_c11_wmem",   32'(a_wmem_addr), 0);
        check("bp_c11_in_rdy", 32'(a_in_rdy), 1);
      end
      if (c == 13) begin
        check("bp_c13_out_v",  32'(a_out_v), 1);
        check("bp_c13_out_nf", 32'(a_out_nf), 1);
      end
      next_cycle();
    end
    cyc = 23;
    check("bp_handoffs", 32'(hs_nf.size()), 4);
    for (int i = 0; i < hs_nf.size() && i < 4; i++) begin
      check("bp_nf_order", 32'(hs_nf[i]), i % 2);
    end

    // ---------------- mid-row reset pulsed in cycle 5 ----------------
    apply_reset();
    for (int c = 0; c < 13; c++) begin
      cyc = c; in_v = 1'b1; out_rdy = 1'b1; rst = (c == 5);
      #1;
      if (c >= 6 && c <= 11) check("mrst_out_v", 32'(a_out_v), 0);
      if (c >= 6 && c <= 9) begin
        check("mrst_in_rdy", 32'(a_in_rdy), 1);
        check("mrst_wr_en",  32'(a_ib_wr_en), 1);
        check("mrst_wmem",   32'(a_wmem_addr), c - 6);
      end
      if (c == 6 || c == 7) check("mrst_acc_en", 32'(a_acc_en), 0);
      if (c == 8) begin
        check("mrst_acc_en_c8", 32'(a_acc_en), 1);
        check("mrst_sf_clr_c8", 32'(a_sf_clr), 1);
      end
      if (c == 12) begin
        check("mrst_out_v_c12",  32'(a_out_v), 1);
        check("mrst_out_nf_c12", 32'(a_out_nf), 0);
      end
      next_cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
